phase_cycle_controller: RTL and testbench

Parametrised multi-phase cycle controller for the micro-motor sequencer back end. It runs a configurable period timer and generates NUM_PHASES independent on/off phase windows per period. Each period it advances a row/column pattern-memory address with selectable scan order, and completes after a programmed number of periods (one-shot) or repeats indefinitely (continuous). It sits between the configuration bus and the pattern memory / driver output stage.

---
 rtl/phase_cycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_phase_cycle_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_cycle_controller.sv
// rtl/phase_cycle_controller.sv - multi-phase period timer with pattern-memory scan addressing
//
// Ports:
//   clock                  rising-edge clock for all state
//   reset                  synchronous active-high reset, clears state and config
//   timer_enable           run gate; low pauses the timer while running
//   write_config_n         active-low config write strobe (ignored while busy)
//   config_address[5:0]    config register address
//   config_data[15:0]      config write data
//   start                  start request (needs timer_enable high)
//   row_select/col_select  current pattern-memory row/column address
//   phase_active           per-phase window decode of the current count
//   inverter_select        config passthrough register
//   row_col_select         config passthrough register
//   period_tick            high in the last cycle of each period
//   update_cycle_complete  held in DONE, single-cycle pulse in continuous mode
//   busy                   high while running
module phase_cycle_controller #(
  parameter int TIMER_WIDTH        = 32,
  parameter int MEM_ADDRESS_LENGTH = 7,
  parameter int NUM_OF_DRIVERS     = 16,
  parameter int NUM_PHASES         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          timer_enable,
  input  logic                          write_config_n,
  input  logic [5:0]                    config_address,
  input  logic [15:0]                   config_data,
  input  logic                          start,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic [NUM_PHASES-1:0]         phase_active,
  output logic [NUM_OF_DRIVERS-1:0]     inverter_select,
  output logic [NUM_OF_DRIVERS-1:0]     row_col_select,
  output logic                          period_tick,
  output logic                          update_cycle_complete,
  output logic                          busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                    state;
  logic [TIMER_WIDTH-1:0]        count;
  logic [TIMER_WIDTH-1:0]        period;
  logic [31:0]                   target;
  logic [31:0]                   cycles_done;
  logic [MEM_ADDRESS_LENGTH-1:0] row_limit;
  logic [MEM_ADDRESS_LENGTH-1:0] col_limit;
  logic [MEM_ADDRESS_LENGTH-1:0] row;
  logic [MEM_ADDRESS_LENGTH-1:0] col;
  logic [MEM_ADDRESS_LENGTH-1:0] row_next;
  logic [MEM_ADDRESS_LENGTH-1:0] col_next;
  logic [NUM_OF_DRIVERS-1:0]     inverter_reg;
  logic [NUM_OF_DRIVERS-1:0]     row_col_reg;
  logic [1:0]                    mode;
  logic [TIMER_WIDTH-1:0]        on_time  [NUM_PHASES];
  logic [TIMER_WIDTH-1:0]        off_time [NUM_PHASES];
  logic                          complete;

  logic running;
  logic period_end;
  logic last_period;

  // Registers wider than 16 bits are written one half at a time; bits at or
  // above TIMER_WIDTH simply fall off when narrowed back.
  function automatic logic [TIMER_WIDTH-1:0] set_half(
    input logic [TIMER_WIDTH-1:0] cur,
    input logic                   hi,
    input logic [15:0]            d
  );
    logic [31:0] w;
    w = 32'(cur);
    if (hi) w[31:16] = d;
    else    w[15:0]  = d;
    return w[TIMER_WIDTH-1:0];
  endfunction

  assign running     = (state == ST_RUN) && timer_enable;
  assign period_end  = (count == period);
  assign last_period = (target != 32'd0) && ((cycles_done + 32'd1) == target);

  // Next scan address: the fast axis steps every period, the slow axis steps
  // when the fast axis wraps, and the slow axis wraps at its own limit.
  always_comb begin
    row_next = row;
    col_next = col;
    if (mode[1]) begin
      if (row == row_limit) begin
        row_next = '0;
        col_next = (col == col_limit) ? '0 : col + 1'b1;
      end else begin
        row_next = row + 1'b1;
      end
    end else begin
      if (col == col_limit) begin
        col_next = '0;
        row_next = (row == row_limit) ? '0 : row + 1'b1;
      end else begin
        col_next = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      period       <= '0;
      target       <= '0;
      cycles_done  <= '0;
      row_limit    <= '0;
      col_limit    <= '0;
      row          <= '0;
      col          <= '0;
      inverter_reg <= '0;
      row_col_reg  <= '0;
      mode         <= '0;
      complete     <= 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        on_time[k]  <= '0;
        off_time[k] <= '0;
      end
    end else begin
      // Configuration is frozen for the whole run.
      if (!write_config_n && (state != ST_RUN)) begin
        case (config_address)
          6'h00: period       <= set_half(period, 1'b0, config_data);
          6'h01: period       <= set_half(period, 1'b1, config_data);
          6'h02: target[15:0]  <= config_data;
          6'h03: target[31:16] <= config_data;
          6'h04: row_limit    <= config_data[MEM_ADDRESS_LENGTH-1:0];
          6'h05: col_limit    <= config_data[MEM_ADDRESS_LENGTH-1:0];
          6'h06: inverter_reg <= config_data[NUM_OF_DRIVERS-1:0];
          6'h07: row_col_reg  <= config_data[NUM_OF_DRIVERS-1:0];
          6'h08: mode         <= config_data[1:0];
          default: begin
            // Phase k owns the four words starting at 0x10 + 4k.
            for (int k = 0; k < NUM_PHASES; k++) begin
              if (config_address[5:2] == 4'(4 + k)) begin
                case (config_address[1:0])
                  2'd0: on_time[k]  <= set_half(on_time[k],  1'b0, config_data);
                  2'd1: on_time[k]  <= set_half(on_time[k],  1'b1, config_data);
                  2'd2: off_time[k] <= set_half(off_time[k], 1'b0, config_data);
                  default: off_time[k] <= set_half(off_time[k], 1'b1, config_data);
                endcase
              end
            end
          end
        endcase
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && timer_enable) begin
            state       <= ST_RUN;
            count       <= '0;
            row         <= '0;
            col         <= '0;
            cycles_done <= '0;
            complete    <= 1'b0;
          end
        end
        ST_RUN: begin
          // The continuous-mode pulse lasts exactly one cycle.
          complete <= 1'b0;
          if (timer_enable) begin
            if (period_end) begin
              count <= '0;
              row   <= row_next;
              col   <= col_next;
              if (last_period) begin
                complete <= 1'b1;
                if (mode[0]) begin
                  cycles_done <= '0;
                end else begin
                  cycles_done <= cycles_done + 32'd1;
                  state       <= ST_DONE;
                end
              end else begin
                cycles_done <= cycles_done + 32'd1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    phase_active = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      phase_active[k] = running && (on_time[k] <= count) && (count < off_time[k]);
    end
  end

  assign period_tick           = running && period_end;
  assign busy                  = (state == ST_RUN);
  assign update_cycle_complete = complete;
  assign row_select            = row;
  assign col_select            = col;
  assign inverter_select       = inverter_reg;
  assign row_col_select        = row_col_reg;

endmodule

// File: tb/tb_phase_cycle_controller.sv
// tb/tb_phase_cycle_controller.sv - randomized and directed bench for phase_cycle_controller
module tb_phase_cycle_controller;

  localparam int TW  = 32;
  localparam int MAL = 7;
  localparam int ND  = 16;
  localparam int NP  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           timer_enable = 1'b0;
  logic           write_config_n = 1'b1;
  logic [5:0]     config_address = '0;
  logic [15:0]    config_data = '0;
  logic           start = 1'b0;
  logic [MAL-1:0] row_select;
  logic [MAL-1:0] col_select;
  logic [NP-1:0]  phase_active;
  logic [ND-1:0]  inverter_select;
  logic [ND-1:0]  row_col_select;
  logic           period_tick;
  logic           update_cycle_complete;
  logic           busy;

  phase_cycle_controller #(
    .TIMER_WIDTH(TW), .MEM_ADDRESS_LENGTH(MAL), .NUM_OF_DRIVERS(ND), .NUM_PHASES(NP)
  ) dut (
    .clock(clock), .reset(reset), .timer_enable(timer_enable),
    .write_config_n(write_config_n), .config_address(config_address),
    .config_data(config_data), .start(start),
    .row_select(row_select), .col_select(col_select), .phase_active(phase_active),
    .inverter_select(inverter_select), .row_col_select(row_col_select),
    .period_tick(period_tick), .update_cycle_complete(update_cycle_complete), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the run is described by n, the number of enabled cycles
  // since start; count, period number and scan index all follow from n.
  longint unsigned m_p, m_t, m_n;
  longint unsigned m_on [NP];
  longint unsigned m_off[NP];
  int              m_rl, m_cl, m_row, m_col, m_state;  // 0 idle, 1 run, 2 done
  logic [15:0]     m_inv, m_rcs;
  logic [1:0]      m_mode;
  bit              m_pulse;
  localparam longint unsigned TMASK = (TW == 32) ? 64'hFFFF_FFFF : ((64'd1 << TW) - 1);

  int cyc_no = 0;
  int busy_cnt;
  int tick_q[$];
  int pulse_q[$];
  int rc_q[$];

  function automatic longint unsigned put16(longint unsigned cur, bit hi, logic [15:0] d);
    if (hi) return (cur & 64'h0000_FFFF) | (longint'(d) << 16);
    return (cur & 64'hFFFF_0000) | longint'(d);
  endfunction

  task automatic model_reset();
    m_p = 0; m_t = 0; m_n = 0; m_rl = 0; m_cl = 0; m_row = 0; m_col = 0;
    m_state = 0; m_inv = 0; m_rcs = 0; m_mode = 0; m_pulse = 0;
    for (int k = 0; k < NP; k++) begin m_on[k] = 0; m_off[k] = 0; end
  endtask

  task automatic model_write(input int a, input logic [15:0] d);
    if (a == 0 || a == 1)      m_p = put16(m_p, a[0], d) & TMASK;
    else if (a == 2 || a == 3) m_t = put16(m_t, a[0], d);
    else if (a == 4) m_rl = int'(d) % (1 << MAL);
    else if (a == 5) m_cl = int'(d) % (1 << MAL);
    else if (a == 6) m_inv = d;
    else if (a == 7) m_rcs = d;
    else if (a == 8) m_mode = d[1:0];
    else if (a >= 16 && (a - 16) / 4 < NP) begin
      int k = (a - 16) / 4;
      if (a % 4 < 2) m_on[k]  = put16(m_on[k],  a[0], d) & TMASK;
      else           m_off[k] = put16(m_off[k], a[0], d) & TMASK;
    end
  endtask

  task automatic model_scan();
    longint unsigned idx;
    idx = (m_n / (m_p + 1)) % longint'((m_rl + 1) * (m_cl + 1));
    if (m_mode[1]) begin m_col = int'(idx) / (m_rl + 1); m_row = int'(idx) % (m_rl + 1); end
    else           begin m_row = int'(idx) / (m_cl + 1); m_col = int'(idx) % (m_cl + 1); end
  endtask

  task automatic model_advance(input bit rst, input bit en, input bit wr_n,
                               input logic [5:0] a, input logic [15:0] d, input bit st);
    longint unsigned cnt;
    bit pulse_n = 0;
    if (rst) begin model_reset(); return; end
    cnt = m_n % (m_p + 1);
    if (m_state != 1) begin
      if (!wr_n) model_write(int'(a), d);
      if (st && en) begin m_state = 1; m_n = 0; m_row = 0; m_col = 0; end
    end else if (en) begin
      m_n++;
      if (cnt == m_p) begin
        model_scan();
        if (m_t != 0 && (m_n / (m_p + 1)) % m_t == 0) begin
          if (m_mode[0]) pulse_n = 1;
          else m_state = 2;
        end
      end
    end
    m_pulse = pulse_n;
  endtask

  task automatic check_outputs(input bit en);
    longint unsigned cnt;
    logic [NP-1:0] exp_pa;
    bit run;
    run = (m_state == 1) && en;
    cnt = m_n % (m_p + 1);
    for (int k = 0; k < NP; k++) exp_pa[k] = run && (m_on[k] <= cnt) && (cnt < m_off[k]);
    check_val("busy",         32'(busy),                  32'(m_state == 1));
    check_val("row_select",   32'(row_select),            32'(m_row));
    check_val("col_select",   32'(col_select),            32'(m_col));
    check_val("phase_active", 32'(phase_active),          32'(exp_pa));
    check_val("period_tick",  32'(period_tick),           32'(run && cnt == m_p));
    check_val("complete",     32'(update_cycle_complete), 32'((m_state == 2) || m_pulse));
    check_val("inverter",     32'(inverter_select),       32'(m_inv));
    check_val("row_col_sel",  32'(row_col_select),        32'(m_rcs));
  endtask

  // One clock cycle: drive just after the falling edge, check, then let the edge pass.
  task automatic cyc(input bit rst, input bit en, input bit wr_n,
                     input logic [5:0] a, input logic [15:0] d, input bit st);
    reset = rst; timer_enable = en; write_config_n = wr_n;
    config_address = a; config_data = d; start = st;
    #1;
    check_outputs(en);
    if (busy) begin busy_cnt++; rc_q.push_back(int'(row_select) * 16 + int'(col_select)); end
    if (period_tick) tick_q.push_back(cyc_no);
    if (update_cycle_complete && busy) pulse_q.push_back(cyc_no);
    model_advance(rst, en, wr_n, a, d, st);
    cyc_no++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 6'h0, 16'h0, 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    cyc(0, 1, 0, a, d, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 1, 6'h0, 16'h0, 0);
  endtask

  task automatic go(output int s);
    busy_cnt = 0; tick_q.delete(); pulse_q.delete(); rc_q.delete();
    s = cyc_no;
    cyc(0, 1, 1, 6'h0, 16'h0, 1);
  endtask

  function automatic int first_gap(int s);
    return (tick_q.size() > 0) ? tick_q[0] - s : -1;
  endfunction

  int s;
  int exp_cf[7] = '{0, 1, 2, 16, 17, 18, 0};
  int exp_rf[7] = '{0, 16, 1, 17, 2, 18, 0};

  initial begin
    model_reset();
    @(negedge clock);
    do_reset(2);
    check_val("reset_busy", 32'(busy), 32'd0);

    // Reset in the middle of a run
    wr(6'h00, 16'd9); wr(6'h02, 16'd3); go(s); idle(5);
    do_reset(2);
    #1;
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_row",  32'(row_select), 32'd0);
    check_val("rst_mid_done", 32'(update_cycle_complete), 32'd0);
    @(negedge clock);
    wr(6'h02, 16'd1); go(s); idle(5);
    check_val("p0_run_len", 32'(busy_cnt), 32'd1);

    // One-shot run
    do_reset(1);
    wr(6'h00, 16'd9); wr(6'h02, 16'd3); wr(6'h10, 16'd2); wr(6'h12, 16'd5);
    wr(6'h05, 16'd2); wr(6'h04, 16'd1); wr(6'h06, 16'hA5C3); wr(6'h07, 16'h0F0F);
    go(s); idle(35);
    check_val("oneshot_busy_len", 32'(busy_cnt), 32'd30);
    check_val("oneshot_ticks",    32'(tick_q.size()), 32'd3);
    check_val("oneshot_first",    32'(first_gap(s)), 32'd10);
    check_val("oneshot_held",     32'(update_cycle_complete), 32'd1);

    // Write while busy is ignored, same write in DONE applies
    go(s); idle(3); wr(6'h00, 16'd2); idle(40);
    check_val("busy_wr_gap",   32'(first_gap(s)), 32'd10);
    check_val("busy_wr_ticks", 32'(tick_q.size()), 32'd3);
    wr(6'h00, 16'd2); go(s); idle(15);
    check_val("done_wr_gap",   32'(first_gap(s)), 32'd3);

    // Scan wrap, column-fast then row-fast
    do_reset(1);
    wr(6'h04, 16'd1); wr(6'h05, 16'd2); go(s); idle(7);
    for (int i = 0; i < 7; i++)
      check_val("scan_col_fast", (rc_q.size() > i) ? 32'(rc_q[i]) : 32'hFFFF, 32'(exp_cf[i]));
    do_reset(1);
    wr(6'h04, 16'd1); wr(6'h05, 16'd2); wr(6'h08, 16'd2); go(s); idle(7);
    for (int i = 0; i < 7; i++)
      check_val("scan_row_fast", (rc_q.size() > i) ? 32'(rc_q[i]) : 32'hFFFF, 32'(exp_rf[i]));

    // Continuous mode
    do_reset(1);
    wr(6'h08, 16'd1); wr(6'h00, 16'd4); wr(6'h02, 16'd2); go(s); idle(35);
    check_val("cont_pulses", 32'(pulse_q.size()), 32'd3);
    check_val("cont_spacing", (pulse_q.size() > 1) ? 32'(pulse_q[1] - pulse_q[0]) : 32'hFFFF, 32'd10);
    check_val("cont_busy", 32'(busy_cnt), 32'd35);

    // Pause at count 3
    do_reset(1);
    wr(6'h00, 16'd9); wr(6'h02, 16'd1); wr(6'h12, 16'd10); go(s); idle(3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 6'h0, 16'h0, 0);
      check_val("pause_pa", 32'(phase_active), 32'd0);
    end
    idle(20);
    check_val("pause_period", 32'(first_gap(s)), 32'd15);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      do_reset(1);
      for (int a = 0; a < 9; a++)
        wr(6'(a), (a == 1 || a == 3) ? 16'd0 : (a >= 6 ? 16'($urandom) : 16'($urandom_range(0, 12))));
      wr(6'h02, 16'($urandom_range(0, 4)));
      for (int k = 0; k < NP; k++) begin
        wr(6'(16 + 4 * k), 16'($urandom_range(0, 12)));
        wr(6'(18 + 4 * k), 16'($urandom_range(0, 12)));
      end
      go(s);
      for (int i = 0; i < 90; i++) begin
        logic [5:0] a;
        logic [15:0] d;
        a = 6'($urandom_range(0, 47));
        d = ((a < 4 || a >= 16) && a[0]) ? 16'd0 : 16'($urandom_range(0, 12));
        cyc(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 6) != 0, a, d,
            ($urandom % 12) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
